// File: rtl/adma_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================
// Package : adma_defs  -- shared encodings for the ADMA RAM arbiter
// Rev     : 1.0
// ============================================================
package adma_defs;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_G0   = 3'b010,
        ST_G1   = 3'b100
    } arb_state_e;

    localparam int   RAM_RD_LAT = 1;
    localparam logic PORT_ADMA  = 1'b0;
    localparam logic PORT_HOST  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/adma_ram_arbiter_if.sv
`default_nettype none
// ============================================================
// Interface : adma_ram_arbiter_if  -- requester ports plus RAM port
// Rev       : 1.0
// ============================================================
interface adma_ram_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              req0, lock0, wr0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              grant0, rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1, lock1, wr1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              grant1, rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic [ADDR_W-1:0] ram_address;
    logic              ram_read, ram_write;
    logic [DATA_W-1:0] data_to_ram;
    logic [DATA_W-1:0] data_from_ram;

    modport slave (
        input  req0, lock0, wr0, addr0, wdata0,
        input  req1, lock1, wr1, addr1, wdata1,
        input  data_from_ram,
        output grant0, rdata0, rvalid0,
        output grant1, rdata1, rvalid1,
        output ram_address, ram_read, ram_write, data_to_ram
    );

    modport master (
        output req0, lock0, wr0, addr0, wdata0,
        output req1, lock1, wr1, addr1, wdata1,
        output data_from_ram,
        input  grant0, rdata0, rvalid0,
        input  grant1, rdata1, rvalid1,
        input  ram_address, ram_read, ram_write, data_to_ram
    );
endinterface
`default_nettype wire

// File: rtl/adma_ram_arbiter_rd_return_pipe.sv
`default_nettype none
// ============================================================
// Module : rd_return_pipe  -- delays read-issued flag and port tag, demuxes RAM data
// Rev    : 1.0
// ============================================================
module rd_return_pipe
    import adma_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk_i,
    input  wire logic              rst_ni,
    input  wire logic              issue_i,
    input  wire logic              tag_i,
    input  wire logic [DATA_W-1:0] data_from_ram_i,
    output logic      [DATA_W-1:0] rdata0_o,
    output logic                   rvalid0_o,
    output logic      [DATA_W-1:0] rdata1_o,
    output logic                   rvalid1_o
);
    logic [RAM_RD_LAT-1:0] vld_q;
    logic [RAM_RD_LAT-1:0] tag_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            tag_q <= '0;
        end else begin
            vld_q[0] <= issue_i;
            tag_q[0] <= tag_i;
            for (int i = 1; i < RAM_RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // The tag, not the current grant, decides who gets the returning word.
    assign rvalid0_o = vld_q[RAM_RD_LAT-1] && (tag_q[RAM_RD_LAT-1] == PORT_ADMA);
    assign rvalid1_o = vld_q[RAM_RD_LAT-1] && (tag_q[RAM_RD_LAT-1] == PORT_HOST);
    assign rdata0_o  = rvalid0_o ? data_from_ram_i : '0;
    assign rdata1_o  = rvalid1_o ? data_from_ram_i : '0;

endmodule
`default_nettype wire

// File: rtl/adma_ram_arbiter.sv
`default_nettype none
// ============================================================
// Module : adma_ram_arbiter  -- round-robin RAM arbiter with burst lock and cap
// Rev    : 1.0
// ============================================================
module adma_ram_arbiter
    import adma_defs::*;
#(
    parameter int MAX_BURST = 16,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 32
) (
    input wire logic          CLK,
    input wire logic          RESET,
    adma_ram_arbiter_if.slave bus
);
    localparam int               CNT_W   = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    arb_state_e       state_q;
    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d;
    logic             last_grant_q;
    logic             acc0, acc1, issue_rd;

    assign burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            burst_cnt_q  <= '0;
            last_grant_q <= PORT_HOST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    burst_cnt_q <= '0;
                    if (bus.req0 && bus.req1)
                        state_q <= (last_grant_q == PORT_ADMA) ? ST_G1 : ST_G0;
                    else if (bus.req0)
                        state_q <= ST_G0;
                    else if (bus.req1)
                        state_q <= ST_G1;
                end
                ST_G0: begin
                    if (!bus.req0) begin
                        state_q      <= bus.req1 ? ST_G1 : ST_IDLE;
                        last_grant_q <= PORT_ADMA;
                        burst_cnt_q  <= '0;
                    end else if (bus.req1 && (!bus.lock0 || burst_cnt_q == CNT_MAX)) begin
                        state_q      <= ST_G1;
                        last_grant_q <= PORT_ADMA;
                        burst_cnt_q  <= '0;
                    end else begin
                        burst_cnt_q  <= burst_cnt_d;
                    end
                end
                ST_G1: begin
                    if (!bus.req1) begin
                        state_q      <= bus.req0 ? ST_G0 : ST_IDLE;
                        last_grant_q <= PORT_HOST;
                        burst_cnt_q  <= '0;
                    end else if (bus.req0 && (!bus.lock1 || burst_cnt_q == CNT_MAX)) begin
                        state_q      <= ST_G0;
                        last_grant_q <= PORT_HOST;
                        burst_cnt_q  <= '0;
                    end else begin
                        burst_cnt_q  <= burst_cnt_d;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant0 = (state_q == ST_G0);
    assign bus.grant1 = (state_q == ST_G1);
    assign acc0       = bus.grant0 && bus.req0;
    assign acc1       = bus.grant1 && bus.req1;

    always_comb begin
        bus.ram_address = '0;
        bus.data_to_ram = '0;
        bus.ram_read    = 1'b0;
        bus.ram_write   = 1'b0;
        if (acc0) begin
            bus.ram_address = bus.addr0;
            bus.data_to_ram = bus.wdata0;
            bus.ram_write   = bus.wr0;
            bus.ram_read    = !bus.wr0;
        end else if (acc1) begin
            bus.ram_address = bus.addr1;
            bus.data_to_ram = bus.wdata1;
            bus.ram_write   = bus.wr1;
            bus.ram_read    = !bus.wr1;
        end
    end

    assign issue_rd = bus.ram_read;

    rd_return_pipe #(
        .DATA_W (DATA_W)
    ) u_rd_return_pipe (
        .clk_i           (CLK),
        .rst_ni          (RESET),
        .issue_i         (issue_rd),
        .tag_i           (acc1 ? PORT_HOST : PORT_ADMA),
        .data_from_ram_i (bus.data_from_ram),
        .rdata0_o        (bus.rdata0),
        .rvalid0_o       (bus.rvalid0),
        .rdata1_o        (bus.rdata1),
        .rvalid1_o       (bus.rvalid1)
    );

endmodule
`default_nettype wire

// File: tb/tb_adma_ram_arbiter.sv
`default_nettype none
// ============================================================
// Module : tb_adma_ram_arbiter  -- directed and random checks against a cycle model
// Rev    : 1.0
// ============================================================
module tb_adma_ram_arbiter;
    localparam int MAX_BURST = 16;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    adma_ram_arbiter_if #(.ADDR_W(64), .DATA_W(32)) bus ();

    adma_ram_arbiter #(
        .MAX_BURST (MAX_BURST),
        .ADDR_W    (64),
        .DATA_W    (32)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: who owns the RAM, accesses made in this tenure, last port to
    // give up the RAM, and a read waiting to come back.
    int m_owner;
    int m_tenure;
    int m_last;
    bit m_pend;
    int m_pend_port;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic p_req(input int p);
        return (p == 1) ? bus.req1 : bus.req0;
    endfunction
    function automatic logic p_lock(input int p);
        return (p == 1) ? bus.lock1 : bus.lock0;
    endfunction
    function automatic logic p_wr(input int p);
        return (p == 1) ? bus.wr1 : bus.wr0;
    endfunction

    task automatic cyc_check();
        logic        acc, wr;
        logic [63:0] addr;
        logic [31:0] wd;
        @(negedge CLK);
        acc  = (m_owner >= 0) && p_req(m_owner);
        wr   = p_wr(m_owner);
        addr = (m_owner == 1) ? bus.addr1 : bus.addr0;
        wd   = (m_owner == 1) ? bus.wdata1 : bus.wdata0;
        chk("grant0",      64'(bus.grant0),      64'(m_owner == 0));
        chk("grant1",      64'(bus.grant1),      64'(m_owner == 1));
        chk("ram_read",    64'(bus.ram_read),    64'(acc && !wr));
        chk("ram_write",   64'(bus.ram_write),   64'(acc && wr));
        chk("ram_address", bus.ram_address,      acc ? addr : 64'd0);
        chk("data_to_ram", 64'(bus.data_to_ram), acc ? 64'(wd) : 64'd0);
        chk("rvalid0",     64'(bus.rvalid0),     64'(m_pend && m_pend_port == 0));
        chk("rvalid1",     64'(bus.rvalid1),     64'(m_pend && m_pend_port == 1));
        chk("rdata0",      64'(bus.rdata0),      (m_pend && m_pend_port == 0) ? 64'(bus.data_from_ram) : 64'd0);
        chk("rdata1",      64'(bus.rdata1),      (m_pend && m_pend_port == 1) ? 64'(bus.data_from_ram) : 64'd0);
        chk("rw_excl",     64'(bus.ram_read & bus.ram_write), 64'd0);
        chk("grant_excl",  64'(bus.grant0 & bus.grant1),      64'd0);
    endtask

    task automatic cyc_end();
        int h, o;
        h = m_owner;
        if (!RESET) begin
            m_owner = -1; m_tenure = 0; m_last = 1; m_pend = 1'b0; m_pend_port = 0;
        end else begin
            m_pend      = (h >= 0) && p_req(h) && !p_wr(h);
            m_pend_port = h;
            if (h < 0) begin
                if (bus.req0 && bus.req1) m_owner = 1 - m_last;
                else if (bus.req0)        m_owner = 0;
                else if (bus.req1)        m_owner = 1;
                m_tenure = 0;
            end else begin
                o = 1 - h;
                if (!p_req(h)) begin
                    m_last = h; m_owner = p_req(o) ? o : -1; m_tenure = 0;
                end else if (p_req(o) && (!p_lock(h) || m_tenure + 1 >= MAX_BURST)) begin
                    m_last = h; m_owner = o; m_tenure = 0;
                end else begin
                    m_tenure++;
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req0 = 0; bus.lock0 = 0; bus.wr0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.lock1 = 0; bus.wr1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.data_from_ram = '0;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        cyc_check();
        cyc_end();
        RESET = 1'b1;
    endtask

    initial begin
        int  n_acc0, n_g1;
        bit  seen_g1, prev_g0, handover_ok;

        clear_inputs();
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        m_owner = -1; m_tenure = 0; m_last = 1; m_pend = 1'b0; m_pend_port = 0;
        do_reset();

        // Reset state
        cyc_check();
        chk("rst_grant0", 64'(bus.grant0), 64'd0);
        chk("rst_grant1", 64'(bus.grant1), 64'd0);
        cyc_end();

        // Single requester read
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 64'h40;
        cyc_check();
        chk("sr_no_grant_yet", 64'(bus.grant0), 64'd0);
        cyc_end();
        cyc_check();
        chk("sr_grant0", 64'(bus.grant0), 64'd1);
        chk("sr_read", 64'(bus.ram_read), 64'd1);
        chk("sr_addr", bus.ram_address, 64'h40);
        cyc_end();
        bus.req0 = 0; bus.data_from_ram = 32'hDEADBEEF;
        cyc_check();
        chk("sr_rvalid0", 64'(bus.rvalid0), 64'd1);
        chk("sr_rdata0", 64'(bus.rdata0), 64'hDEADBEEF);
        cyc_end();
        cyc_check(); cyc_end();

        // Reset mid-burst: read in flight is dropped
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 64'h100; bus.data_from_ram = 32'h0BAD_F00D;
        cyc_check(); cyc_end();
        RESET = 1'b0;
        cyc_check();
        chk("rmb_read_issued", 64'(bus.ram_read), 64'd1);
        cyc_end();
        RESET = 1'b1; bus.req0 = 0;
        cyc_check();
        chk("rmb_no_rvalid0", 64'(bus.rvalid0), 64'd0);
        chk("rmb_grant0", 64'(bus.grant0), 64'd0);
        chk("rmb_read", 64'(bus.ram_read), 64'd0);
        cyc_end();

        // Tie then round-robin alternation
        bus.req0 = 1; bus.req1 = 1; bus.lock0 = 0; bus.lock1 = 0;
        bus.wr0 = 1; bus.wr1 = 1; bus.addr0 = 64'hA0; bus.addr1 = 64'hB0;
        bus.wdata0 = 32'h1111_0000; bus.wdata1 = 32'h2222_0000;
        cyc_check(); cyc_end();
        for (int i = 0; i < 4; i++) begin
            cyc_check();
            chk("rr_grant0", 64'(bus.grant0), 64'((i % 2) == 0));
            chk("rr_grant1", 64'(bus.grant1), 64'((i % 2) == 1));
            cyc_end();
        end
        clear_inputs();
        do_reset();

        // Burst cap: port 0 locked, port 1 waiting
        bus.req0 = 1; bus.lock0 = 1; bus.wr0 = 1; bus.addr0 = 64'h300; bus.wdata0 = 32'hC0DE_0000;
        bus.req1 = 1; bus.lock1 = 0; bus.wr1 = 0; bus.addr1 = 64'h310;
        n_acc0 = 0; seen_g1 = 0; prev_g0 = 0; handover_ok = 0;
        for (int i = 0; i < 24 && !seen_g1; i++) begin
            cyc_check();
            if (bus.grant1) begin
                seen_g1 = 1; handover_ok = prev_g0;
            end
            if (bus.grant0 && bus.ram_write) n_acc0++;
            prev_g0 = bus.grant0;
            cyc_end();
        end
        chk("burst_acc0", 64'(n_acc0), 64'd16);
        chk("burst_no_bubble", 64'(handover_ok), 64'd1);

        // Lock without contention: port 1 keeps the grant
        bus.req0 = 0; bus.lock0 = 0; bus.req1 = 1; bus.lock1 = 1;
        cyc_check(); cyc_end();
        n_g1 = 0;
        for (int i = 0; i < 40; i++) begin
            cyc_check();
            if (bus.grant1) n_g1++;
            cyc_end();
        end
        chk("lock_hold_g1", 64'(n_g1), 64'd40);
        clear_inputs();
        do_reset();

        // Read routing across hand-over
        bus.req0 = 1; bus.wr0 = 0; bus.addr0 = 64'h180;
        cyc_check(); cyc_end();
        bus.req1 = 1; bus.wr1 = 1; bus.addr1 = 64'h200; bus.wdata1 = 32'h12345678;
        cyc_check();
        chk("rt_read0", 64'(bus.ram_read), 64'd1);
        cyc_end();
        bus.req0 = 0; bus.data_from_ram = 32'hA5A5_0001;
        cyc_check();
        chk("rt_grant1", 64'(bus.grant1), 64'd1);
        chk("rt_write", 64'(bus.ram_write), 64'd1);
        chk("rt_wdata", 64'(bus.data_to_ram), 64'h12345678);
        chk("rt_addr", bus.ram_address, 64'h200);
        chk("rt_rvalid0", 64'(bus.rvalid0), 64'd1);
        chk("rt_rvalid1", 64'(bus.rvalid1), 64'd0);
        chk("rt_rdata0", 64'(bus.rdata0), 64'hA5A50001);
        cyc_end();
        clear_inputs();
        cyc_check(); cyc_end();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            RESET         = ($urandom_range(63) != 0);
            bus.req0      = ($urandom_range(3) != 0);
            bus.req1      = ($urandom_range(3) != 0);
            bus.lock0     = ($urandom_range(1) != 0);
            bus.lock1     = ($urandom_range(1) != 0);
            bus.wr0       = ($urandom_range(1) != 0);
            bus.wr1       = ($urandom_range(1) != 0);
            bus.addr0     = {$urandom, $urandom};
            bus.addr1     = {$urandom, $urandom};
            bus.wdata0    = $urandom;
            bus.wdata1    = $urandom;
            bus.data_from_ram = $urandom;
            cyc_check();
            cyc_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adma_ram_arbiter.md
Name: adma_ram_arbiter

Overview:
Arbitrates the single system-RAM port between two requesters:
- Port 0 is the ADMA engine (descriptor fetch and data transfer).
- Port 1 is the host register/CPU side.

The block uses round-robin arbitration with burst locking and a starvation cap. It sits between the ADMA state machine's RAM outputs and the RAM model/controller. It owns the ram_address, ram_read, ram_write and data_to_ram signals.

Parameters:
MAX_BURST, 16, max consecutive accesses by one holder while the other port is requesting (must be >= 2).
ADDR_W, 64, address width.
DATA_W, 32, data width.

Ports:
CLK  in  1  system clock; all logic on posedge.
RESET  in  1  synchronous, active-low reset (asserted when 0).
req0  in  1  ADMA port requests RAM; held until done.
lock0  in  1  ADMA asks to keep grant for a burst.
wr0  in  1  ADMA access type (1=write, 0=read).
addr0  in  ADDR_W  ADMA address.
wdata0  in  DATA_W  ADMA write data.
grant0  out  1  ADMA port owns RAM this cycle.
rdata0  out  DATA_W  read data to ADMA.
rvalid0  out  1  rdata0 valid.
req1, lock1, wr1, addr1, wdata1  in  1/1/1/ADDR_W/DATA_W  host port, same meaning.
grant1, rdata1, rvalid1  out  1/DATA_W/1  host port, same meaning.
ram_address  out  ADDR_W  RAM address.
ram_read  out  1  RAM read strobe.
ram_write  out  1  RAM write strobe.
data_to_ram  out  DATA_W  RAM write data.
data_from_ram  in  DATA_W  RAM read data (1-cycle latency).

Behaviour:
- Reset (RESET==0 at posedge):
  - State goes to ST_IDLE. grant0, grant1, rvalid0 and rvalid1 go to 0.
  - burst_cnt=0; last_grant=1, so port 0 wins the first tie.
  - Any read in flight is dropped: no rvalid after reset.
- States (one-hot): ST_IDLE=3'b001, ST_G0=3'b010, ST_G1=3'b100. grantN = (state==ST_GN), registered.
- ST_IDLE transitions:
  - req0 & req1: go to the port != last_grant.
  - Single request: go to that port.
  - No request: stay.
  - Arbitration latency is 1 cycle (req seen at edge k, grant high after edge k).
- Access rule: an access is issued in any cycle where grantN & reqN.
  - ram_address=addrN; data_to_ram=wdataN; ram_write=wrN; ram_read=~wrN. These are combinational from the holder, 0 latency.
  - Otherwise ram_read=ram_write=0, ram_address=0, data_to_ram=0.
- Read return: a read issued at cycle k gives rvalidN=1 and rdataN=data_from_ram at cycle k+1, for the port that issued it.
  - Routing is by a registered port tag, even if the grant has moved.
  - rdata of the other port is 0.
- ST_GN transitions (M = the other port), in priority order:
  1. ~reqN: go to ST_GM if reqM, else ST_IDLE.
  2. reqM & (~lockN | burst_cnt==MAX_BURST-1): go to ST_GM. The current-cycle access still completes.
  3. Otherwise stay.
  - Hand-over is direct, with no idle bubble. last_grant <= N on leaving ST_GN.
- burst_cnt:
  - Increments on each issued access in ST_GN, saturating at MAX_BURST-1.
  - Clears on every state change.
  - Width is clog2(MAX_BURST).
- Lock without contention: a holder keeps the grant indefinitely while reqM==0. The cap applies only when the other port is waiting.
- Simultaneous release and request: ~reqN and reqM in the same cycle hands over on the next edge.
- RAM must never see ram_read & ram_write both high. Neither grant may ever be high together with the other.

Decomposition:
- Shared package (adma_defs): state encodings ST_IDLE/ST_G0/ST_G1, RAM read latency constant RAM_RD_LAT=1, and PORT_ADMA=0 / PORT_HOST=1.
- One natural sub-module: rd_return_pipe. It registers the read-issued flag and port tag for RAM_RD_LAT cycles and demuxes data_from_ram to rdata0/rdata1 with rvalid0/rvalid1.

Test Plan:
- Reset mid-burst:
  - Stimulus: grant0 active, read issued at addr0=64'h100; RESET=0 in that cycle's following edge.
  - Required: no rvalid0; grants 0; ram_read=0 next cycle.
- Single requester read:
  - Stimulus: req0=1, wr0=0, addr0=64'h40, RAM returns 32'hDEADBEEF.
  - Required: grant0 rises 1 cycle later; ram_read=1 with ram_address=64'h40; rvalid0=1 and rdata0=32'hDEADBEEF one cycle after.
- Tie and round-robin:
  - Stimulus: req0=req1=1 from IDLE after reset, lock0=lock1=0.
  - Required: grant0 first. Then grants alternate 0,1,0,1 every cycle.
- Burst cap:
  - Stimulus: lock0=1, req0 held; req1 asserted at the same time.
  - Required: exactly 16 port-0 accesses, then grant1 on the next cycle with no idle cycle.
- Lock without contention:
  - Stimulus: lock1=1, req1 held for 40 cycles, req0=0.
  - Required: grant1 held all 40 cycles. burst_cnt saturates at 15 with no release.
- Read routing across hand-over:
  - Stimulus: port 0 issues a read on its last granted cycle; port 1 writes wdata1=32'h12345678 to 64'h200 the next cycle.
  - Required: rvalid0 in that cycle, not rvalid1. ram_write=1 with data_to_ram=32'h12345678.
